seq_divider: RTL and testbench
==============================

# seq_divider

Parametrised multi-cycle restoring divider with a start/done handshake, signed and unsigned modes, remainder output, and divide-by-zero and overflow flags. It is the next generation of the team's fixed-width serial divider: one quotient bit per clock, with register footprint scaled by `DW`/`VW`. Used by datapath blocks such as frequency/period calculators that need an occasional wide division without a combinational array.

## Interface
- `DW`, 26: dividend and quotient width, ≥ 2.
- `VW`, 14: divisor and remainder width, 2 ≤ `VW` ≤ `DW`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only when `ready`=1.
- `is_signed` in 1: 1 = two's-complement operands, 0 = unsigned; sampled with `start`.
- `dividend` in `DW`: sampled with `start`.
- `divisor` in `VW`: sampled with `start`.
- `ready` out 1: idle, able to accept `start`.
- `done` out 1: one-cycle pulse; results valid.
- `quotient` out `DW`: result, held until the next `done`.
- `remainder` out `VW`: result, held until the next `done`.
- `div_zero` out 1: divisor was 0; held with results.
- `overflow` out 1: signed most-negative ÷ −1; held with results.

## Operation
- **FSM states:** IDLE → CALC → FIX → IDLE.
- **IDLE:**
  - `ready`=1.
  - `start`=1 latches the mode, |dividend|, |divisor| and both sign bits.
  - Clears the partial remainder (`VW`+1 bits) and step counter (width `$clog2(DW+1)`).
  - Goes to CALC.
- **CALC:** one restoring step per cycle, MSB first.
  - Shift the next dividend bit into the partial remainder.
  - If partial remainder ≥ {0,|divisor|}: subtract and shift 1 into the quotient; else shift 0.
  - Goes to FIX after exactly `DW` steps.
- **FIX:** applies signs, registers the outputs, pulses `done`, returns to IDLE.
- **Signed rules:**
  - Quotient truncates toward zero.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Magnitudes of most-negative operands are held unsigned; no loss.
- **Divide by zero** (divisor = 0, either mode):
  - `quotient` = all ones, `remainder` = 0, `div_zero`=1.
  - Same latency as a normal operation.
- **Overflow:** signed, dividend = −2^(`DW`−1), divisor = −1.
  - `quotient` = dividend, `remainder` = 0, `overflow`=1.
- **Flags:** `div_zero` and `overflow` are never both 1, and both clear on the next `done`.
- **Busy behaviour:**
  - `start` while `ready`=0 is ignored, with no queueing.
  - Operand inputs may change freely after the sampling edge.

## Timing
- **Reset values:** state IDLE, `ready`=1, `done`=0, `quotient`=0, `remainder`=0, `div_zero`=0, `overflow`=0.
- **Latency:** `start` sampled at edge k.
  - `ready` is low from edge k to edge k+`DW`+1.
  - `done` is high for the single cycle after edge k+`DW`+1.
  - Outputs update at that same edge.
  - The latency is fixed and independent of operand values.
- **Back-to-back:** `ready` is 1 in the `done` cycle, so the next `start` may be sampled at edge k+`DW`+2. Throughput is one result per `DW`+2 cycles.
- **Reset mid-operation:** `rst_n` low aborts immediately; no `done` is produced and all outputs return to reset values.

## Structure
- **Package `div_pkg`:** FSM state enum (IDLE/CALC/FIX), counter-width function, flag encodings.
- **Sub-module `div_step`:**
  - Combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, |divisor|.
  - Outputs: next partial remainder, quotient bit.
  - The top level holds the FSM, counter, sign handling and output registers.

## Test plan
All scenarios use `DW`=26, `VW`=14.
- **Unsigned:** 1000000 ÷ 7 → `quotient`=142857, `remainder`=1, `done` exactly 27 cycles after the `start` edge, flags 0.
- **Signed:** −100 ÷ 7 → `quotient`=−14 (0x3FFFFF2), `remainder`=−2 (0x3FFE). 100 ÷ −7 → `quotient`=−14, `remainder`=2.
- **Divide by zero:** 12345 ÷ 0 in both modes → `quotient`=0x3FFFFFF, `remainder`=0, `div_zero`=1.
- **Overflow:** signed 0x2000000 ÷ 0x3FFF → `quotient`=0x2000000, `remainder`=0, `overflow`=1. In unsigned mode the same operands → `quotient`=2048, `remainder`=2048, `overflow`=0.
- **Start while busy:** a second `start` with different operands during CALC is ignored; results match the first operation, and a back-to-back `start` in the `done` cycle is accepted.
- **Reset mid-operation:** `rst_n` low at step 10 → no `done`, outputs 0, `ready`=1. A fresh division afterwards returns the correct result.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the serial restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Special-case outcome latched at start; only one can ever apply.
    typedef enum logic [1:0] {
        FLAG_NONE     = 2'd0,
        FLAG_DIV_ZERO = 2'd1,
        FLAG_OVERFLOW = 2'd2
    } flag_e;

    function automatic int unsigned cnt_width(input int unsigned dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on magnitudes.
module div_step #(
    parameter int unsigned VW = 14
) (
    input  logic [VW-1:0] rem_i,
    input  logic          bit_i,
    input  logic [VW-1:0] dvs_i,
    output logic [VW-1:0] rem_c_o,
    output logic          qbit_c_o
);

    logic [VW:0] shifted;

    // Partial remainder stays below |divisor|, so VW bits hold it between steps.
    always_comb begin
        shifted  = {rem_i, bit_i};
        qbit_c_o = (shifted >= {1'b0, dvs_i});
        rem_c_o  = qbit_c_o ? VW'(shifted - {1'b0, dvs_i}) : shifted[VW-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed/unsigned
// with remainder, divide-by-zero and overflow flags.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned DW = 26,
    parameter int unsigned VW = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          is_signed,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          ready,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero,
    output logic          overflow
);

    localparam int unsigned   CW      = cnt_width(DW);
    localparam logic [DW-1:0] DVD_MIN = {1'b1, {(DW-1){1'b0}}};

    state_e        state_q, state_d;
    flag_e         flag_q, flag_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW-1:0] prem_q, prem_d;
    logic          sgn_a_q, sgn_a_d;
    logic          sgn_b_q, sgn_b_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          dz_q, dz_d;
    logic          ov_q, ov_d;

    logic [VW-1:0] step_rem_c;
    logic          step_bit_c;

    div_step #(.VW(VW)) u_step (
        .rem_i    (prem_q),
        .bit_i    (dvd_q[DW-1]),
        .dvs_i    (dvs_q),
        .rem_c_o  (step_rem_c),
        .qbit_c_o (step_bit_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            flag_q  <= FLAG_NONE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            sgn_a_q <= 1'b0;
            sgn_b_q <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            sgn_a_q <= sgn_a_d;
            sgn_b_q <= sgn_b_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        flag_d  = flag_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        sgn_a_d = sgn_a_q;
        sgn_b_d = sgn_b_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        ov_d    = ov_q;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (start) begin
                    // Sign bits are kept only in signed mode; the datapath works on magnitudes.
                    sgn_a_d = is_signed & dividend[DW-1];
                    sgn_b_d = is_signed & divisor[VW-1];
                    dvd_d   = sgn_a_d ? DW'(-dividend) : dividend;
                    dvs_d   = sgn_b_d ? VW'(-divisor) : divisor;
                    prem_d  = '0;
                    cnt_d   = '0;
                    if (divisor == '0)
                        flag_d = FLAG_DIV_ZERO;
                    else if (is_signed && dividend == DVD_MIN && divisor == '1)
                        flag_d = FLAG_OVERFLOW;
                    else
                        flag_d = FLAG_NONE;
                    ready_d = 1'b0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                // Dividend register doubles as the quotient shift register.
                prem_d = step_rem_c;
                dvd_d  = {dvd_q[DW-2:0], step_bit_c};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                done_d  = 1'b1;
                case (flag_q)
                    FLAG_DIV_ZERO: begin
                        quo_d = '1;
                        rem_d = '0;
                        dz_d  = 1'b1;
                        ov_d  = 1'b0;
                    end
                    FLAG_OVERFLOW: begin
                        quo_d = DVD_MIN;
                        rem_d = '0;
                        dz_d  = 1'b0;
                        ov_d  = 1'b1;
                    end
                    default: begin
                        quo_d = (sgn_a_q ^ sgn_b_q) ? DW'(-dvd_q) : dvd_q;
                        rem_d = sgn_a_q ? VW'(-prem_q) : prem_q;
                        dz_d  = 1'b0;
                        ov_d  = 1'b0;
                    end
                endcase
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
    assign overflow  = ov_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at DW=26, VW=14.
module tb_seq_divider;

    localparam int unsigned DW  = 26;
    localparam int unsigned VW  = 14;
    localparam int          LAT = DW + 1;

    typedef struct packed {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          dz;
        logic          ov;
    } res_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          is_signed;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          ready;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;
    logic          overflow;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference using host integer division.
    function automatic res_t model(input bit sgn, input logic [DW-1:0] a, input logic [VW-1:0] b);
        longint sa, sb, q, r;
        res_t   e;
        e = '0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        if (sb == 0) begin
            e.q  = '1;
            e.dz = 1'b1;
        end else if (sgn && sa == -(longint'(1) << (DW - 1)) && sb == -1) begin
            e.q  = a;
            e.ov = 1'b1;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            e.q = q[DW-1:0];
            e.r = r[VW-1:0];
        end
        return e;
    endfunction

    // Called #1 after a rising edge; start is sampled at the next edge.
    task automatic start_op(input bit sgn, input logic [DW-1:0] a, input logic [VW-1:0] b, input res_t e);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic collect(output res_t obs, output int lat);
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
        end
        obs = {quotient, remainder, div_zero, overflow};
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({ready, done, quotient, remainder, div_zero, overflow} !== {1'b1, 1'b0, {DW{1'b0}}, {VW{1'b0}}, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_values got rdy=%b done=%b q=%h r=%h dz=%b ov=%b want rdy=1 rest 0",
                     ready, done, quotient, remainder, div_zero, overflow);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_unsigned;
        res_t obs, e;
        int   lat;
        start_op(1'b0, 26'd1000000, 14'd7, '{q: 26'd142857, r: 14'd1, dz: 1'b0, ov: 1'b0});
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL unsigned_busy got ready=%b want 0", ready);
        end
        collect(obs, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e) begin
            n_fail++;
            $display("FAIL unsigned_result got %h want %h", obs, e);
        end
        n_checks++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL unsigned_latency got %0d want %0d", lat, LAT);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0 || quotient !== 26'd142857) begin
            n_fail++;
            $display("FAIL done_pulse_hold got done=%b q=%h want done=0 q=%h", done, quotient, 26'd142857);
        end
    endtask

    task automatic test_signed;
        res_t obs, e;
        int   lat;
        start_op(1'b1, 26'h3FFFF9C, 14'd7, '{q: 26'h3FFFFF2, r: 14'h3FFE, dz: 1'b0, ov: 1'b0});
        collect(obs, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || lat !== LAT) begin
            n_fail++;
            $display("FAIL signed_neg_dividend got %h lat=%0d want %h lat=%0d", obs, lat, e, LAT);
        end
        start_op(1'b1, 26'd100, 14'h3FF9, '{q: 26'h3FFFFF2, r: 14'd2, dz: 1'b0, ov: 1'b0});
        collect(obs, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || lat !== LAT) begin
            n_fail++;
            $display("FAIL signed_neg_divisor got %h lat=%0d want %h lat=%0d", obs, lat, e, LAT);
        end
    endtask

    task automatic test_div_zero;
        res_t obs, e;
        int   lat;
        for (int m = 0; m < 2; m++) begin
            start_op(m[0], 26'd12345, 14'd0, '{q: 26'h3FFFFFF, r: 14'd0, dz: 1'b1, ov: 1'b0});
            collect(obs, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e || lat !== LAT) begin
                n_fail++;
                $display("FAIL div_zero_mode%0d got %h lat=%0d want %h lat=%0d", m, obs, lat, e, LAT);
            end
        end
    endtask

    task automatic test_overflow;
        res_t obs, e;
        int   lat;
        start_op(1'b1, 26'h2000000, 14'h3FFF, '{q: 26'h2000000, r: 14'd0, dz: 1'b0, ov: 1'b1});
        collect(obs, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || lat !== LAT) begin
            n_fail++;
            $display("FAIL overflow_signed got %h lat=%0d want %h lat=%0d", obs, lat, e, LAT);
        end
        start_op(1'b0, 26'h2000000, 14'h3FFF, '{q: 26'd2048, r: 14'd2048, dz: 1'b0, ov: 1'b0});
        collect(obs, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || lat !== LAT) begin
            n_fail++;
            $display("FAIL overflow_unsigned got %h lat=%0d want %h lat=%0d", obs, lat, e, LAT);
        end
    endtask

    task automatic test_busy_back_to_back;
        res_t obs, e;
        int   lat;
        start_op(1'b0, 26'd5000000, 14'd123, model(1'b0, 26'd5000000, 14'd123));
        repeat (5) @(posedge clk);
        #1;
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 26'd999;
        divisor   = 14'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        collect(obs, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || lat !== LAT - 6) begin
            n_fail++;
            $display("FAIL busy_ignored got %h lat=%0d want %h lat=%0d", obs, lat, e, LAT - 6);
        end
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_in_done_cycle got %b want 1", ready);
        end
        start_op(1'b1, 26'h3FF0000, 14'd1000, model(1'b1, 26'h3FF0000, 14'd1000));
        n_checks++;
        if (done !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_accept got done=%b ready=%b want 0 0", done, ready);
        end
        collect(obs, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || lat !== LAT) begin
            n_fail++;
            $display("FAIL back_to_back_result got %h lat=%0d want %h lat=%0d", obs, lat, e, LAT);
        end
    endtask

    task automatic test_reset_mid_op;
        res_t obs, e;
        int   lat;
        int   seen;
        start_op(1'b0, 26'd777777, 14'd55, model(1'b0, 26'd777777, 14'd55));
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        exp_q.delete();
        n_checks++;
        if ({ready, done, quotient, remainder, div_zero, overflow} !== {1'b1, 1'b0, {DW{1'b0}}, {VW{1'b0}}, 2'b00}) begin
            n_fail++;
            $display("FAIL mid_reset_values got rdy=%b done=%b q=%h r=%h dz=%b ov=%b want rdy=1 rest 0",
                     ready, done, quotient, remainder, div_zero, overflow);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        n_checks++;
        if (seen !== 0 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_no_done got dones=%0d ready=%b want 0 1", seen, ready);
        end
        start_op(1'b1, 26'h3000001, 14'd97, model(1'b1, 26'h3000001, 14'd97));
        collect(obs, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (obs !== e || lat !== LAT) begin
            n_fail++;
            $display("FAIL after_reset_result got %h lat=%0d want %h lat=%0d", obs, lat, e, LAT);
        end
    endtask

    task automatic test_random;
        res_t          obs, e;
        int            lat;
        bit            sgn;
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        for (int i = 0; i < 12; i++) begin
            sgn = 1'($urandom);
            a   = DW'($urandom);
            b   = (i % 3 == 0) ? VW'($urandom_range(1, 15)) : VW'($urandom);
            if (i % 4 == 1) b = -b;
            start_op(sgn, a, b, model(sgn, a, b));
            collect(obs, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (obs !== e || lat !== LAT) begin
                n_fail++;
                $display("FAIL random_%0d s=%b a=%h b=%h got %h lat=%0d want %h lat=%0d",
                         i, sgn, a, b, obs, lat, e, LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_busy_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
